operand_fetch: RTL and testbench

//  Operand-fetch sequencer between the instruction decoder and the execute stage.

---
 rtl/operand_fetch.sv | 166 ++++++++++++++++
 tb/tb_operand_fetch.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// ---------------------------------------------------------------------------
// operand_fetch
//   Operand-fetch sequencer between the instruction decoder and the execute
//   stage. It drives the readnum of a single-read-port register file (whose
//   data_out is combinational on readnum). Over one or two cycles it captures
//   operand A (Rn) and, when requested, operand B (Rm). It then presents the
//   A/B pair to execute through a valid/ready handshake.
//
//   Build option:
//     WB_BYPASS_EN - when defined, a register-file write to the index being
//                    read in the same cycle forwards wb_data into the
//                    captured operand. When undefined, the wb_* ports are
//                    present but ignored.
//
//   Ports:
//     clk, reset_n              clock, asynchronous active-low reset
//     in_valid/in_ready         decoder request handshake
//     in_rn, in_rm, in_need_b   request payload (B forced to 0 if !in_need_b)
//     readnum                   register-file read index
//     rf_data                   register-file read data
//     wb_write/_writenum/_data  register-file write port (bypass only)
//     out_valid/out_ready       execute handshake
//     a_out, b_out              captured operands
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | waiting for a request; operands keep their last values
//   READ_A | readnum = Rn; operand A captured on the next edge
//   READ_B | readnum = Rm; operand B captured on the next edge
//   HOLD   | out_valid high; wait for execute, may accept next request
// ---------------------------------------------------------------------------
module operand_fetch #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rn,
    input  logic [ADDR_W-1:0] in_rm,
    input  logic              in_need_b,
    output logic [ADDR_W-1:0] readnum,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              wb_write,
    input  logic [ADDR_W-1:0] wb_writenum,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ_A = 2'd1,
        READ_B = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   rn_q, rn_d;
    logic [ADDR_W-1:0]   rm_q, rm_d;
    logic                need_b_q, need_b_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   capt_data;
    logic                accept;

    // Read index depends only on state and latched indices, so it is settled
    // before the capture mux looks at it.
    always_comb begin
        readnum = '0;
        case (state_q)
            READ_A:  readnum = rn_q;
            READ_B:  readnum = rm_q;
            default: readnum = '0;
        endcase
    end

`ifdef WB_BYPASS_EN
    // A write landing on the same edge is not yet visible on rf_data, so
    // forward the write data instead.
    always_comb begin
        capt_data = rf_data;
        if (wb_write && (wb_writenum == readnum)) begin
            capt_data = wb_data;
        end
    end
`else
    logic unused_wb;
    assign unused_wb = ^{wb_write, wb_writenum, wb_data};
    assign capt_data = rf_data;
`endif

    assign in_ready  = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == HOLD);
    assign a_out     = a_q;
    assign b_out     = b_q;

    always_comb begin
        state_d  = state_q;
        rn_d     = rn_q;
        rm_d     = rm_q;
        need_b_d = need_b_q;
        a_d      = a_q;
        b_d      = b_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    rn_d     = in_rn;
                    rm_d     = in_rm;
                    need_b_d = in_need_b;
                    state_d  = READ_A;
                end
            end
            READ_A: begin
                a_d = capt_data;
                if (need_b_q) begin
                    state_d = READ_B;
                end else begin
                    b_d     = '0;
                    state_d = HOLD;
                end
            end
            READ_B: begin
                b_d     = capt_data;
                state_d = HOLD;
            end
            HOLD: begin
                // Back-to-back: a new request can be taken on the same edge
                // that execute consumes the current pair.
                if (accept) begin
                    rn_d     = in_rn;
                    rm_d     = in_rm;
                    need_b_d = in_need_b;
                    state_d  = READ_A;
                end else if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            rn_q     <= '0;
            rm_q     <= '0;
            need_b_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            state_q  <= state_d;
            rn_q     <= rn_d;
            rm_q     <= rm_d;
            need_b_q <= need_b_d;
            a_q      <= a_d;
            b_q      <= b_d;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_rn;
    logic [2:0]  in_rm;
    logic        in_need_b;
    logic [2:0]  readnum;
    logic [15:0] rf_data;
    logic        wb_write;
    logic [2:0]  wb_writenum;
    logic [15:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] a_out;
    logic [15:0] b_out;

    logic [15:0] rf [8];

    int checks;
    int errors;

    operand_fetch #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rn      (in_rn),
        .in_rm      (in_rm),
        .in_need_b  (in_need_b),
        .readnum    (readnum),
        .rf_data    (rf_data),
        .wb_write   (wb_write),
        .wb_writenum(wb_writenum),
        .wb_data    (wb_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .a_out      (a_out),
        .b_out      (b_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: combinational read, write on rising edge.
    assign rf_data = rf[readnum];
    always @(posedge clk) begin
        if (wb_write) rf[wb_writenum] <= wb_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [2:0] idx, input logic [15:0] val);
        wb_write    = 1'b1;
        wb_writenum = idx;
        wb_data     = val;
        tick();
        wb_write    = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 0; in_rn = 0; in_rm = 0; in_need_b = 0;
        wb_write = 0; wb_writenum = 0; wb_data = 0; out_ready = 0;
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (a_out !== 16'h0) begin errors++; $display("FAIL reset_a got %h exp 0000", a_out); end
        checks++; if (b_out !== 16'h0) begin errors++; $display("FAIL reset_b got %h exp 0000", b_out); end
        checks++; if (readnum !== 3'd0) begin errors++; $display("FAIL reset_readnum got %0d exp 0", readnum); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_two_operands();
        preload(3'd2, 16'h002A);
        preload(3'd5, 16'h0027);
        in_valid = 1; in_rn = 3'd2; in_rm = 3'd5; in_need_b = 1; out_ready = 1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL t1_in_ready got %b exp 1", in_ready); end
        tick();
        in_valid = 0;
        checks++; if (readnum !== 3'd2) begin errors++; $display("FAIL t1_readnum_a got %0d exp 2", readnum); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t1_valid_k1 got %b exp 0", out_valid); end
        tick();
        checks++; if (readnum !== 3'd5) begin errors++; $display("FAIL t1_readnum_b got %0d exp 5", readnum); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t1_valid_k2 got %b exp 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t1_valid_k3 got %b exp 1", out_valid); end
        checks++; if (a_out !== 16'h002A) begin errors++; $display("FAIL t1_a got %h exp 002a", a_out); end
        checks++; if (b_out !== 16'h0027) begin errors++; $display("FAIL t1_b got %h exp 0027", b_out); end
        checks++; if (readnum !== 3'd0) begin errors++; $display("FAIL t1_readnum_hold got %0d exp 0", readnum); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t1_idle_valid got %b exp 0", out_valid); end
        checks++; if (a_out !== 16'h002A || b_out !== 16'h0027) begin errors++; $display("FAIL t1_idle_retain got a=%h b=%h exp a=002a b=0027", a_out, b_out); end
    endtask

    task automatic test_single_operand();
        preload(3'd3, 16'h9122);
        preload(3'd5, 16'h0027);
        in_valid = 1; in_rn = 3'd3; in_rm = 3'd5; in_need_b = 0; out_ready = 1;
        tick();
        in_valid = 0;
        checks++; if (readnum !== 3'd3) begin errors++; $display("FAIL t2_readnum_a got %0d exp 3", readnum); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t2_valid_k1 got %b exp 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t2_valid_k2 got %b exp 1", out_valid); end
        checks++; if (a_out !== 16'h9122) begin errors++; $display("FAIL t2_a got %h exp 9122", a_out); end
        checks++; if (b_out !== 16'h0000) begin errors++; $display("FAIL t2_b got %h exp 0000", b_out); end
        checks++; if (readnum === 3'd5) begin errors++; $display("FAIL t2_readnum_not5 got %0d exp not 5", readnum); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t2_idle got %b exp 0", out_valid); end
    endtask

    task automatic test_backpressure();
        preload(3'd2, 16'h002A);
        preload(3'd5, 16'h0027);
        preload(3'd7, 16'h1000);
        in_valid = 1; in_rn = 3'd2; in_rm = 3'd5; in_need_b = 1; out_ready = 0;
        tick();
        in_valid = 0;
        tick();
        tick();
        in_valid = 1; in_rn = 3'd7; in_rm = 3'd0; in_need_b = 0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t3_bp_valid cyc%0d got %b exp 1", i, out_valid); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL t3_bp_in_ready cyc%0d got %b exp 0", i, in_ready); end
            checks++; if (a_out !== 16'h002A || b_out !== 16'h0027) begin errors++; $display("FAIL t3_bp_stable cyc%0d got a=%h b=%h exp a=002a b=0027", i, a_out, b_out); end
            tick();
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t3_bp_still_hold got %b exp 1", out_valid); end
        out_ready = 1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL t3_in_ready_comb got %b exp 1", in_ready); end
        tick();
        in_valid = 0;
        checks++; if (readnum !== 3'd7) begin errors++; $display("FAIL t3_b2b_readnum got %0d exp 7", readnum); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t3_b2b_valid got %b exp 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t3_b2b_hold got %b exp 1", out_valid); end
        checks++; if (a_out !== 16'h1000 || b_out !== 16'h0000) begin errors++; $display("FAIL t3_b2b_data got a=%h b=%h exp a=1000 b=0000", a_out, b_out); end
        tick();
    endtask

    task automatic test_rn_eq_rm();
        preload(3'd7, 16'h1000);
        in_valid = 1; in_rn = 3'd7; in_rm = 3'd7; in_need_b = 1; out_ready = 1;
        tick();
        in_valid = 0;
        checks++; if (readnum !== 3'd7 || out_valid !== 1'b0) begin errors++; $display("FAIL t6_k1 got readnum=%0d valid=%b exp 7/0", readnum, out_valid); end
        tick();
        checks++; if (readnum !== 3'd7 || out_valid !== 1'b0) begin errors++; $display("FAIL t6_k2 got readnum=%0d valid=%b exp 7/0", readnum, out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t6_valid got %b exp 1", out_valid); end
        checks++; if (a_out !== 16'h1000 || b_out !== 16'h1000) begin errors++; $display("FAIL t6_data got a=%h b=%h exp a=1000 b=1000", a_out, b_out); end
        tick();
    endtask

    task automatic test_reset_midflight();
        preload(3'd2, 16'h002A);
        preload(3'd5, 16'h0027);
        in_valid = 1; in_rn = 3'd2; in_rm = 3'd5; in_need_b = 1; out_ready = 1;
        tick();
        in_valid = 0;
        tick();
        checks++; if (readnum !== 3'd5 || a_out !== 16'h002A) begin errors++; $display("FAIL t4_in_read_b got readnum=%0d a=%h exp 5/002a", readnum, a_out); end
        reset_n = 1'b0;
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t4_rst_valid got %b exp 0", out_valid); end
        checks++; if (a_out !== 16'h0 || b_out !== 16'h0) begin errors++; $display("FAIL t4_rst_data got a=%h b=%h exp 0000/0000", a_out, b_out); end
        checks++; if (readnum !== 3'd0) begin errors++; $display("FAIL t4_rst_readnum got %0d exp 0", readnum); end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL t4_after_rel got in_ready=%b valid=%b exp 1/0", in_ready, out_valid); end
    endtask

    task automatic test_bypass();
        logic [15:0] exp_a;
`ifdef WB_BYPASS_EN
        exp_a = 16'h1000;
`else
        exp_a = 16'h002A;
`endif
        preload(3'd2, 16'h002A);
        in_valid = 1; in_rn = 3'd2; in_rm = 3'd0; in_need_b = 0; out_ready = 1;
        tick();
        in_valid = 0;
        wb_write = 1; wb_writenum = 3'd2; wb_data = 16'h1000;
        tick();
        wb_write = 0;
        checks++; if (out_valid !== 1'b1 || a_out !== exp_a) begin errors++; $display("FAIL t5_bypass_hit got valid=%b a=%h exp 1/%h", out_valid, a_out, exp_a); end
        tick();
        preload(3'd2, 16'h002A);
        in_valid = 1; in_rn = 3'd2; in_rm = 3'd0; in_need_b = 0;
        tick();
        in_valid = 0;
        wb_write = 1; wb_writenum = 3'd4; wb_data = 16'h5555;
        tick();
        wb_write = 0;
        checks++; if (out_valid !== 1'b1 || a_out !== 16'h002A) begin errors++; $display("FAIL t5_bypass_miss got valid=%b a=%h exp 1/002a", out_valid, a_out); end
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_two_operands();
        test_single_operand();
        test_backpressure();
        test_rn_eq_rm();
        test_reset_midflight();
        test_bypass();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
